// File: rtl/ball_motion_if.sv
// Ball-motion bus: game controller (master) drives serve/tick/paddle, ball_motion (slave) returns position and velocity.
interface ball_motion_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int SPEED_W = 3
);
  logic                       tick;
  logic                       serve;
  logic                       serve_dir;
  logic [SPEED_W-1:0]         speed_x;
  logic [SPEED_W-1:0]         speed_y;
  logic                       paddle_hit;
  logic [X_W-1:0]             ball_x;
  logic [Y_W-1:0]             ball_y;
  logic [2*(SPEED_W+1)-1:0]   out_vector;
  logic                       active;
  logic                       miss_left;
  logic                       miss_right;

  modport master (
    output tick, serve, serve_dir, speed_x, speed_y, paddle_hit,
    input  ball_x, ball_y, out_vector, active, miss_left, miss_right
  );

  modport slave (
    input  tick, serve, serve_dir, speed_x, speed_y, paddle_hit,
    output ball_x, ball_y, out_vector, active, miss_left, miss_right
  );
endinterface

// File: rtl/ball_motion.sv
// Stateful pong ball: serve delay, per-axis speed, wall bounce, paddle reflection, miss detection.
// Optional feature macro BALL_ACCEL_EN: each paddle reflection bumps the x speed (saturating).
module ball_motion #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED_W     = 3,
  parameter int X_START     = 316,
  parameter int Y_START     = 236,
  parameter int SERVE_DELAY = 30
) (
  input logic          clk,
  input logic          rst_n,
  ball_motion_if.slave bus
);
  localparam int AW = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam int VW = SPEED_W + 1;
  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [AW-1:0] XL = AW'(X_MAX + 1 - BALL_SIZE);
  localparam logic [AW-1:0] YL = AW'(Y_MAX + 1 - BALL_SIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, MOVE = 2'd2} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [X_W-1:0]     x_r;
  logic [Y_W-1:0]     y_r;
  logic               dir_x_r;
  logic               dir_y_r;
  logic [SPEED_W-1:0] spd_x_r;
  logic [SPEED_W-1:0] spd_y_r;
  logic [2*VW-1:0]    vec_r;
  logic               active_r;
  logic               miss_l_r;
  logic               miss_r_r;

  logic [AW-1:0]      xe_s, sx_s, x_plus_s, x_minus_s;
  logic [AW-1:0]      ye_s, sy_s, y_plus_s, y_minus_s;
  logic               x_over_s, x_under_s, y_over_s, y_under_s;
  logic [AW-1:0]      y_nxt_s, x_hit_s, x_mv_s;
  logic               dy_nxt_s;
  logic               miss_l_s, miss_r_s;
  logic [SPEED_W-1:0] spd_x_hit_s;

  function automatic logic [VW-1:0] signed_speed(input logic dir, input logic [SPEED_W-1:0] spd);
    logic [VW-1:0] mag;
    mag = VW'(spd);
    return dir ? (VW'(0) - mag) : mag;
  endfunction

  function automatic logic [2*VW-1:0] pack_vec(input logic dx, input logic dy,
                                               input logic [SPEED_W-1:0] sx,
                                               input logic [SPEED_W-1:0] sy);
    return {signed_speed(dx, sx), signed_speed(dy, sy)};
  endfunction

  // Widened candidate positions so comparisons never see wrap-around
  always_comb begin
    xe_s      = AW'(x_r);
    sx_s      = AW'(spd_x_r);
    ye_s      = AW'(y_r);
    sy_s      = AW'(spd_y_r);
    x_plus_s  = xe_s + sx_s;
    x_minus_s = xe_s - sx_s;
    y_plus_s  = ye_s + sy_s;
    y_minus_s = ye_s - sy_s;
    x_over_s  = (x_plus_s > XL);
    x_under_s = (xe_s < sx_s);
    y_over_s  = (y_plus_s > YL);
    y_under_s = (ye_s < sy_s);
  end

  // Next y with wall bounce
  always_comb begin
    y_nxt_s  = ye_s;
    dy_nxt_s = dir_y_r;
    if (!dir_y_r) begin
      if (y_over_s) begin
        y_nxt_s  = YL;
        dy_nxt_s = 1'b1;
      end else begin
        y_nxt_s  = y_plus_s;
        dy_nxt_s = 1'b0;
      end
    end else begin
      if (y_under_s) begin
        y_nxt_s  = '0;
        dy_nxt_s = 1'b0;
      end else begin
        y_nxt_s  = y_minus_s;
        dy_nxt_s = 1'b1;
      end
    end
  end

  // Next x for reflection (reversed direction, clamped) and for a plain move, plus miss flags
  always_comb begin
    if (dir_x_r) begin
      x_hit_s = x_over_s ? XL : x_plus_s;
    end else begin
      x_hit_s = x_under_s ? '0 : x_minus_s;
    end
    x_mv_s   = dir_x_r ? x_minus_s : x_plus_s;
    miss_r_s = !dir_x_r && x_over_s;
    miss_l_s = dir_x_r && x_under_s;
  end

  // Reflection speed update
  always_comb begin
`ifdef BALL_ACCEL_EN
    if (spd_x_r == {SPEED_W{1'b1}}) begin
      spd_x_hit_s = spd_x_r;
    end else begin
      spd_x_hit_s = spd_x_r + SPEED_W'(1);
    end
`else
    spd_x_hit_s = spd_x_r;
`endif
  end

  // Control FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      x_r      <= X_W'(X_START);
      y_r      <= Y_W'(Y_START);
      dir_x_r  <= 1'b0;
      dir_y_r  <= 1'b0;
      spd_x_r  <= '0;
      spd_y_r  <= '0;
      vec_r    <= '0;
      active_r <= 1'b0;
      miss_l_r <= 1'b0;
      miss_r_r <= 1'b0;
    end else begin
      miss_l_r <= 1'b0;
      miss_r_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.serve) begin
            spd_x_r  <= bus.speed_x;
            spd_y_r  <= bus.speed_y;
            dir_x_r  <= bus.serve_dir;
            dir_y_r  <= 1'b0;
            cnt_r    <= CW'(SERVE_DELAY);
            vec_r    <= pack_vec(bus.serve_dir, 1'b0, bus.speed_x, bus.speed_y);
            active_r <= 1'b1;
            state_r  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.tick) begin
            if (cnt_r <= CW'(1)) begin
              cnt_r   <= '0;
              state_r <= MOVE;
            end else begin
              cnt_r <= cnt_r - CW'(1);
            end
          end
        end
        MOVE: begin
          if (bus.tick) begin
            if (bus.paddle_hit) begin
              x_r     <= x_hit_s[X_W-1:0];
              y_r     <= y_nxt_s[Y_W-1:0];
              dir_x_r <= ~dir_x_r;
              dir_y_r <= dy_nxt_s;
              spd_x_r <= spd_x_hit_s;
              vec_r   <= pack_vec(~dir_x_r, dy_nxt_s, spd_x_hit_s, spd_y_r);
            end else if (miss_r_s || miss_l_s) begin
              // y update for this tick is dropped; ball re-parks
              miss_r_r <= miss_r_s;
              miss_l_r <= miss_l_s;
              x_r      <= X_W'(X_START);
              y_r      <= Y_W'(Y_START);
              active_r <= 1'b0;
              state_r  <= IDLE;
            end else begin
              x_r     <= x_mv_s[X_W-1:0];
              y_r     <= y_nxt_s[Y_W-1:0];
              dir_y_r <= dy_nxt_s;
              vec_r   <= pack_vec(dir_x_r, dy_nxt_s, spd_x_r, spd_y_r);
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ball_x     = x_r;
  assign bus.ball_y     = y_r;
  assign bus.out_vector = vec_r;
  assign bus.active     = active_r;
  assign bus.miss_left  = miss_l_r;
  assign bus.miss_right = miss_r_r;
endmodule
